// File: rtl/reg_select_sink.sv
// rtl/reg_select_sink.sv - IR latch, Ra/Rb/Rc field select, 16x32 register bank and bus strobes
module reg_select_sink (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] BusMuxOut,
    input  logic        IRin,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    output logic        R0out,
    output logic        R1out,
    output logic        R2out,
    output logic        R3out,
    output logic        R4out,
    output logic        R5out,
    output logic        R6out,
    output logic        R7out,
    output logic        R8out,
    output logic        R9out,
    output logic        R10out,
    output logic        R11out,
    output logic        R12out,
    output logic        R13out,
    output logic        R14out,
    output logic        R15out,
    output logic [31:0] BusMuxIn_R0,
    output logic [31:0] BusMuxIn_R1,
    output logic [31:0] BusMuxIn_R2,
    output logic [31:0] BusMuxIn_R3,
    output logic [31:0] BusMuxIn_R4,
    output logic [31:0] BusMuxIn_R5,
    output logic [31:0] BusMuxIn_R6,
    output logic [31:0] BusMuxIn_R7,
    output logic [31:0] BusMuxIn_R8,
    output logic [31:0] BusMuxIn_R9,
    output logic [31:0] BusMuxIn_R10,
    output logic [31:0] BusMuxIn_R11,
    output logic [31:0] BusMuxIn_R12,
    output logic [31:0] BusMuxIn_R13,
    output logic [31:0] BusMuxIn_R14,
    output logic [31:0] BusMuxIn_R15,
    output logic [31:0] C_sign_extended,
    output logic [31:0] IR_q,
    output logic        sel_err
);

    logic [31:0] ir_q;
    logic [31:0] ir_d;
    logic [31:0] regs_q [16];
    logic        sel_err_q;
    logic        sel_err_d;

    logic [3:0]  sel;
    logic        any_gr;
    logic        multi_gr;
    logic [15:0] dec;
    logic [15:0] strobe;

    // Field select from the registered IR; overlapping Gr controls OR their fields together
    always_comb begin
        sel = 4'd0;
        if (Gra) sel = sel | ir_q[26:23];
        if (Grb) sel = sel | ir_q[22:19];
        if (Grc) sel = sel | ir_q[18:15];
        any_gr   = Gra | Grb | Grc;
        multi_gr = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
        dec      = any_gr ? (16'd1 << sel) : 16'd0;
        strobe   = (Rout | BAout) ? dec : 16'd0;
    end

    // Next-state for IR and the sticky multi-select error
    always_comb begin
        ir_d      = IRin ? BusMuxOut : ir_q;
        sel_err_d = sel_err_q | (multi_gr & (Rin | Rout | BAout));
    end

    // IR and error flag; clr overrides any load in the same cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            ir_q      <= 32'd0;
            sel_err_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Register bank: the decoded register loads from the bus when Rin is asserted
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (clr) begin
                regs_q[i] <= 32'd0;
            end else if (Rin && dec[i]) begin
                regs_q[i] <= BusMuxOut;
            end
        end
    end

    assign IR_q            = ir_q;
    assign sel_err         = sel_err_q;
    assign C_sign_extended = {{13{ir_q[18]}}, ir_q[18:0]};

    assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
            R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = strobe;

    // R0 used as a base address reads as zero; storage is left alone
    assign BusMuxIn_R0  = (BAout && (sel == 4'd0)) ? 32'd0 : regs_q[0];
    assign BusMuxIn_R1  = regs_q[1];
    assign BusMuxIn_R2  = regs_q[2];
    assign BusMuxIn_R3  = regs_q[3];
    assign BusMuxIn_R4  = regs_q[4];
    assign BusMuxIn_R5  = regs_q[5];
    assign BusMuxIn_R6  = regs_q[6];
    assign BusMuxIn_R7  = regs_q[7];
    assign BusMuxIn_R8  = regs_q[8];
    assign BusMuxIn_R9  = regs_q[9];
    assign BusMuxIn_R10 = regs_q[10];
    assign BusMuxIn_R11 = regs_q[11];
    assign BusMuxIn_R12 = regs_q[12];
    assign BusMuxIn_R13 = regs_q[13];
    assign BusMuxIn_R14 = regs_q[14];
    assign BusMuxIn_R15 = regs_q[15];

endmodule

// File: tb/tb_reg_select_sink.sv
// tb/tb_reg_select_sink.sv - directed-vector bench for reg_select_sink
module tb_reg_select_sink;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] BusMuxOut;
    logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;
    logic [31:0] BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3;
    logic [31:0] BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7;
    logic [31:0] BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11;
    logic [31:0] BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15;
    logic [31:0] C_sign_extended, IR_q;
    logic        sel_err;

    logic [15:0] strobes;
    logic [31:0] rv [16];
    logic [31:0] exp_r [16];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    reg_select_sink dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
        .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
        .BusMuxIn_R0(BusMuxIn_R0), .BusMuxIn_R1(BusMuxIn_R1),
        .BusMuxIn_R2(BusMuxIn_R2), .BusMuxIn_R3(BusMuxIn_R3),
        .BusMuxIn_R4(BusMuxIn_R4), .BusMuxIn_R5(BusMuxIn_R5),
        .BusMuxIn_R6(BusMuxIn_R6), .BusMuxIn_R7(BusMuxIn_R7),
        .BusMuxIn_R8(BusMuxIn_R8), .BusMuxIn_R9(BusMuxIn_R9),
        .BusMuxIn_R10(BusMuxIn_R10), .BusMuxIn_R11(BusMuxIn_R11),
        .BusMuxIn_R12(BusMuxIn_R12), .BusMuxIn_R13(BusMuxIn_R13),
        .BusMuxIn_R14(BusMuxIn_R14), .BusMuxIn_R15(BusMuxIn_R15),
        .C_sign_extended(C_sign_extended), .IR_q(IR_q), .sel_err(sel_err)
    );

    assign strobes = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign rv[0]  = BusMuxIn_R0;
    assign rv[1]  = BusMuxIn_R1;
    assign rv[2]  = BusMuxIn_R2;
    assign rv[3]  = BusMuxIn_R3;
    assign rv[4]  = BusMuxIn_R4;
    assign rv[5]  = BusMuxIn_R5;
    assign rv[6]  = BusMuxIn_R6;
    assign rv[7]  = BusMuxIn_R7;
    assign rv[8]  = BusMuxIn_R8;
    assign rv[9]  = BusMuxIn_R9;
    assign rv[10] = BusMuxIn_R10;
    assign rv[11] = BusMuxIn_R11;
    assign rv[12] = BusMuxIn_R12;
    assign rv[13] = BusMuxIn_R13;
    assign rv[14] = BusMuxIn_R14;
    assign rv[15] = BusMuxIn_R15;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; IRin = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        BusMuxOut = 32'd0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        BusMuxOut = v; IRin = 1;
        tick();
        IRin = 0; BusMuxOut = 32'd0;
    endtask

    task automatic write_reg(input int idx, input logic [31:0] v);
        logic [31:0] ir;
        ir = 32'd0;
        ir[26:23] = idx[3:0];
        load_ir(ir);
        BusMuxOut = v; Gra = 1; Rin = 1;
        tick();
        Gra = 0; Rin = 0; BusMuxOut = 32'd0;
        exp_r[idx] = v;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) check_eq($sformatf("%s_R%0d", tag, i), rv[i], exp_r[i]);
    endtask

    initial begin
        idle();
        clr = 1;
        tick();
        clr = 0;

        // Preload every register with a distinct nonzero value
        for (int i = 0; i < 16; i++) write_reg(i, 32'h1000_0000 + i * 32'h111);
        check_all_regs("preload");

        // Reset with a pending IR load and register write: clr wins
        load_ir(32'h0A18_0000);
        BusMuxOut = 32'h1234_5678; IRin = 1; Gra = 1; Rin = 1; clr = 1;
        tick();
        idle();
        for (int i = 0; i < 16; i++) exp_r[i] = 32'd0;
        check_all_regs("reset");
        check_eq("reset_ir", IR_q, 32'd0);
        check_eq("reset_c", C_sign_extended, 32'd0);
        check_eq("reset_err", {31'd0, sel_err}, 32'd0);
        check_eq("reset_strobes", {16'd0, strobes}, 32'd0);

        // Write R4 through Ra of IR=0x0A180000, then read its strobe
        load_ir(32'h0A18_0000);
        BusMuxOut = 32'hDEAD_BEEF; Gra = 1; Rin = 1;
        tick();
        idle();
        exp_r[4] = 32'hDEAD_BEEF;
        check_all_regs("wr4");
        Gra = 1; Rout = 1; #1;
        check_eq("rd4_strobe", {16'd0, strobes}, 32'h0000_0010);
        Gra = 0; Grb = 1; #1;
        check_eq("rb3_strobe", {16'd0, strobes}, 32'h0000_0008);
        Grb = 0; #1;
        check_eq("no_gr_strobe", {16'd0, strobes}, 32'd0);
        Rout = 0; Gra = 1; #1;
        check_eq("gr_no_out_strobe", {16'd0, strobes}, 32'd0);
        idle();

        // BAout on R0 reads as zero; Rout shows the stored value
        write_reg(0, 32'h0000_0055);
        load_ir(32'h0000_0000);
        Grb = 1; BAout = 1; #1;
        check_eq("ba_r0_strobe", {16'd0, strobes}, 32'h0000_0001);
        check_eq("ba_r0_value", BusMuxIn_R0, 32'd0);
        BAout = 0; Rout = 1; #1;
        check_eq("rout_r0_value", BusMuxIn_R0, 32'h0000_0055);
        idle();
        tick();
        check_eq("r0_storage_kept", BusMuxIn_R0, 32'h0000_0055);

        // Sign extension of the 19-bit constant
        load_ir(32'h0007_FFFF);
        check_eq("cext_neg", C_sign_extended, 32'hFFFF_FFFF);
        load_ir(32'h0003_FFFF);
        check_eq("cext_pos", C_sign_extended, 32'h0003_FFFF);
        load_ir(32'h7FFC_0000);
        check_eq("cext_hi_ignored", C_sign_extended, 32'h0004_0000 | 32'hFFF8_0000);

        // IR load and register write in the same cycle decode with the old IR
        write_reg(3, 32'hCAFE_0003);
        write_reg(2, 32'h2222_2222);
        load_ir(32'h0100_0000);
        BusMuxOut = 32'h0180_0000; IRin = 1; Gra = 1; Rin = 1;
        tick();
        idle();
        exp_r[2] = 32'h0180_0000;
        check_eq("coll_r2", BusMuxIn_R2, 32'h0180_0000);
        check_eq("coll_r3", BusMuxIn_R3, 32'hCAFE_0003);
        check_eq("coll_ir", IR_q, 32'h0180_0000);
        Gra = 1; Rout = 1; #1;
        check_eq("coll_strobe", {16'd0, strobes}, 32'h0000_0008);
        idle();

        // Write with Rout in the same cycle: strobe shows the old value, new value after the edge
        BusMuxOut = 32'h0BAD_F00D; Gra = 1; Rin = 1; Rout = 1; #1;
        check_eq("rin_rout_old", BusMuxIn_R3, 32'hCAFE_0003);
        tick();
        idle();
        check_eq("rin_rout_new", BusMuxIn_R3, 32'h0BAD_F00D);
        exp_r[3] = 32'h0BAD_F00D;

        // Multi-select: Ra=1 | Rb=2 selects R3; error only with a control asserted
        load_ir(32'h0090_0000);
        Gra = 1; Grb = 1;
        tick();
        check_eq("multi_no_ctrl_err", {31'd0, sel_err}, 32'd0);
        Rout = 1; #1;
        check_eq("multi_strobe", {16'd0, strobes}, 32'h0000_0008);
        check_eq("multi_err_pre", {31'd0, sel_err}, 32'd0);
        tick();
        check_eq("multi_err_set", {31'd0, sel_err}, 32'd1);
        idle();
        tick();
        tick();
        check_eq("multi_err_sticky", {31'd0, sel_err}, 32'd1);
        check_all_regs("multi_regs");
        clr = 1;
        tick();
        idle();
        check_eq("multi_err_clr", {31'd0, sel_err}, 32'd0);
        Gra = 1; Rout = 1; #1;
        check_eq("post_clr_decode_r0", {16'd0, strobes}, 32'h0000_0001);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_select_sink.md
# reg_select_sink

Destination/source side of the datapath bus. Latches the instruction register (IR) from the bus and decodes its Ra/Rb/Rc fields under the Gra/Grb/Grc controls. Owns the 16×32 general-purpose register bank that loads from the bus. Drives the one-hot register-out strobes, the 16 register values and the sign-extended constant C into the bus multiplexer and its encoder.

## Interface
- WORD, 32, data word width; fixed at 32, not otherwise supported
- clk  input  1  rising-edge clock
- clr  input  1  reset, synchronous, active-high
- BusMuxOut  input  32  bus value; load source for IR and registers
- IRin  input  1  load IR from BusMuxOut at the next edge
- Gra  input  1  select the Ra field, IR[26:23]
- Grb  input  1  select the Rb field, IR[22:19]
- Grc  input  1  select the Rc field, IR[18:15]
- Rin  input  1  write the selected register from BusMuxOut
- Rout  input  1  drive the selected register onto the bus
- BAout  input  1  drive the selected register as a base address; reads as 0 when R0 is selected
- R0out … R15out  output  1 each  one-hot register-out strobes to the bus encoder
- BusMuxIn_R0 … BusMuxIn_R15  output  32 each  register values to the bus mux
- C_sign_extended  output  32  IR[18:0] sign-extended from bit 18
- IR_q  output  32  current IR contents
- sel_err  output  1  sticky error: more than one Gr asserted during Rin, Rout or BAout

## Operation
- Field select is combinational from registered IR_q:
  - sel = OR of (Gra ? Ra : 0), (Grb ? Rb : 0), (Grc ? Rc : 0).
  - any_gr = Gra | Grb | Grc.
- Decode is 4-to-16 one-hot, dec[sel], qualified by any_gr. If no Gr is asserted there is no decode: no write and no strobe.
- Rin & any_gr: register[sel] <= BusMuxOut at the edge.
- Rout | BAout with any_gr: R{sel}out = 1. All other RNout = 0. Purely combinational, no registering.
- BAout with sel=0: BusMuxIn_R0 = 0 for that cycle. R0 storage is untouched. When BAout is low, or sel≠0, BusMuxIn_R0 = stored R0.
- IRin: IR_q <= BusMuxOut at the edge.
- C_sign_extended = {{13{IR_q[18]}}, IR_q[18:0]}.
- Multiple Gr asserted: sel is the bitwise OR of the chosen fields. That is the defined behaviour, not undefined. If Rin, Rout or BAout is also high, sel_err <= 1 at the edge. sel_err is cleared only by clr.
- Rin together with Rout or BAout is legal. The strobe shows the old value this cycle; the new value appears after the edge.

## Timing
- Reset, with clr high at an edge:
  - IR_q = 0, all 16 registers = 0, sel_err = 0.
  - Consequently C_sign_extended = 0 and all BusMuxIn_RN = 0.
  - Strobes follow the inputs combinationally, so with controls low all RNout = 0.
- clr has priority over IRin and Rin in the same cycle. Neither load takes effect.
- Write latency is 1 edge. A register written at edge k shows on BusMuxIn_RN from just after edge k.
- IRin and Gr/Rin in the same cycle: decode uses the old IR_q. The new fields take effect the cycle after the edge.
- Strobe latency is 0 cycles from Gr/Rout/BAout/IR_q to RNout.
- clr in mid-instruction aborts any pending write at that edge. The following cycles decode from IR_q = 0, i.e. R0.

## Test plan
- Reset: registers preloaded with nonzero values, clr=1 for one edge -> all BusMuxIn_RN = 0, IR_q = 0, C_sign_extended = 0, sel_err = 0.
- Write and read:
  - Setup: IR=0x0A180000 (Ra=4, Rb=3), load bus with 0xDEADBEEF, Gra=1, Rin=1.
  - After the edge: BusMuxIn_R4 = 0xDEADBEEF, all other registers unchanged.
  - Then Gra=1, Rout=1 -> R4out=1 and the other 15 strobes = 0.
- BAout on R0:
  - Setup: R0=0x00000055, IR Rb=0, Grb=1, BAout=1.
  - Response: R0out=1, BusMuxIn_R0 = 0. With Rout instead of BAout: BusMuxIn_R0 = 0x55.
- Constant extension:
  - IR=0x0007FFFF -> C_sign_extended = 0xFFFFFFFF.
  - IR=0x0003FFFF -> C_sign_extended = 0x0003FFFF.
- IR/Rin collision:
  - Setup: old IR Ra=2, bus=0x01800000 (new Ra=3); IRin=1, Gra=1, Rin=1 in one cycle.
  - Response: R2 <= 0x01800000, R3 unchanged. The next cycle with Gra, Rout gives R3out=1.
- Multi-select error:
  - Setup: Ra=1, Rb=2, Gra=Grb=1, Rout=1.
  - Response: R3out=1, and sel_err=1 after the edge. sel_err stays 1 until clr.
